// File: rtl/fir_pkg.sv
// fir_pkg: sizing helpers, signed saturation and tap-index types
// shared by the fir_tap_pipe FIR block and its adder-tree levels.
package fir_pkg;

  typedef logic [15:0] tap_idx_t;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } sat_t;

  function automatic int full_w(
    input int taps,
    input int w,
    input int cw
  );
    return w + cw + $clog2(taps);
  endfunction

  function automatic int lat(input int taps);
    return 1 + $clog2(taps);
  endfunction

  // operand count entering tree level k
  function automatic int lvl_cnt(
    input int taps,
    input int k
  );
    int n;
    n = taps;
    for (int i = 0; i < k; i++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic int lvl_off(
    input int taps,
    input int k
  );
    int o;
    o = 0;
    for (int i = 0; i < k; i++) o += lvl_cnt(taps, i);
    return o;
  endfunction

  function automatic sat_t sat_s(
    input logic signed [63:0] x,
    input int                 ow
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_t r;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    r.sat = 1'b0;
    r.val = x;
    if (x > hi) begin
      r.sat = 1'b1;
      r.val = hi;
    end else if (x < lo) begin
      r.sat = 1'b1;
      r.val = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_add_level.sv
// fir_add_level: one registered pairwise-add level of the FIR tree;
// an odd leftover operand passes through the register unchanged.
module fir_add_level #(
  parameter  int N_IN  = 2,
  parameter  int W     = 8,
  localparam int N_OUT = (N_IN + 1) / 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear_i,
  input  logic                    en_i,
  input  logic                    vld_i,
  input  logic [N_IN-1:0][W-1:0]  opnd_i,
  output logic                    vld_o,
  output logic [N_OUT-1:0][W-1:0] sum_o
);

  logic [N_OUT-1:0][W-1:0] sum_d;
  logic [N_OUT-1:0][W-1:0] sum_q;
  logic                    vld_q;

  for (genvar j = 0; j < N_OUT; j++) begin : g_pair
    if (2 * j + 1 < N_IN) begin : g_add
      assign sum_d[j] = opnd_i[2*j] + opnd_i[2*j+1];
    end else begin : g_pass
      assign sum_d[j] = opnd_i[2*j];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
      vld_q <= 1'b0;
    end else if (clear_i) begin
      sum_q <= '0;
      vld_q <= 1'b0;
    end else if (en_i) begin
      sum_q <= sum_d;
      vld_q <= vld_i;
    end
  end

  assign sum_o = sum_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/fir_tap_pipe.sv
// fir_tap_pipe: N-tap programmable FIR, pipelined adder tree, valid/ready.
// FIR_SATURATE_EN: clip narrowed output and flag it on out_sat.
module fir_tap_pipe
  import fir_pkg::*;
#(
  parameter int TAPS       = 4,
  parameter int WIDTH      = 8,
  parameter int COEF_WIDTH = 8,
  parameter int OUT_WIDTH  = full_w(TAPS, WIDTH, COEF_WIDTH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         coef_wr,
  input  logic [$clog2(TAPS)-1:0]      coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [WIDTH-1:0]      in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  out,
  output logic                         out_sat
);

  localparam int FULL_W = full_w(TAPS, WIDTH, COEF_WIDTH);
  localparam int PW     = WIDTH + COEF_WIDTH;
  localparam int NLVL   = $clog2(TAPS);
  localparam int NODES  = lvl_off(TAPS, NLVL + 1);

  logic                         en;
  logic signed [COEF_WIDTH-1:0] coef_q [TAPS];
  logic signed [WIDTH-1:0]      d_q    [TAPS];
  logic signed [PW-1:0]         p_q    [TAPS];
  logic                         d_v_q;
  logic                         p_v_q;
  logic [NODES-1:0][FULL_W-1:0] node;
  logic [NLVL:0]                vld;
  logic signed [FULL_W-1:0]     acc;

  assign en       = !(out_valid && !out_ready) && !clear;
  assign in_ready = en;

  // writes land regardless of stall or clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TAPS; i++)
        coef_q[i] <= COEF_WIDTH'(1);
    end else begin
      for (int i = 0; i < TAPS; i++)
        if (coef_wr &&
            tap_idx_t'(coef_addr) == tap_idx_t'(i))
          coef_q[i] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TAPS; i++) d_q[i] <= '0;
      d_v_q <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < TAPS; i++) d_q[i] <= '0;
      d_v_q <= 1'b0;
    end else if (en) begin
      d_v_q <= in_valid;
      if (in_valid) begin
        d_q[0] <= in;
        for (int i = 1; i < TAPS; i++)
          d_q[i] <= d_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TAPS; i++) p_q[i] <= '0;
      p_v_q <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < TAPS; i++) p_q[i] <= '0;
      p_v_q <= 1'b0;
    end else if (en) begin
      p_v_q <= d_v_q;
      for (int i = 0; i < TAPS; i++)
        p_q[i] <= PW'(d_q[i]) * PW'(coef_q[i]);
    end
  end

  for (genvar i = 0; i < TAPS; i++) begin : g_leaf
    assign node[i] = FULL_W'(p_q[i]);
  end
  assign vld[0] = p_v_q;

  for (genvar k = 0; k < NLVL; k++) begin : g_lvl
    localparam int NI = lvl_cnt(TAPS, k);
    localparam int NO = lvl_cnt(TAPS, k + 1);
    localparam int OI = lvl_off(TAPS, k);
    localparam int OO = lvl_off(TAPS, k + 1);

    fir_add_level #(
      .N_IN (NI),
      .W    (FULL_W)
    ) u_lvl (
      .clk     (clk),
      .reset_n (reset_n),
      .clear_i (clear),
      .en_i    (en),
      .vld_i   (vld[k]),
      .opnd_i  (node[OI +: NI]),
      .vld_o   (vld[k+1]),
      .sum_o   (node[OO +: NO])
    );
  end

  assign acc       = node[NODES-1];
  assign out_valid = vld[NLVL];

  if (OUT_WIDTH > FULL_W) begin : g_ext
    assign out     = OUT_WIDTH'(acc);
    assign out_sat = 1'b0;
  end else if (OUT_WIDTH == FULL_W) begin : g_full
    assign out     = acc;
    assign out_sat = 1'b0;
  end else begin : g_red
`ifdef FIR_SATURATE_EN
    sat_t sr;
    logic unused_hi;
    assign sr        = sat_s(64'(acc), OUT_WIDTH);
    assign out       = sr.val[OUT_WIDTH-1:0];
    assign out_sat   = sr.sat;
    assign unused_hi = ^sr.val[63:OUT_WIDTH];
`else
    logic unused_hi;
    assign out       = acc[OUT_WIDTH-1:0];
    assign out_sat   = 1'b0;
    assign unused_hi = ^acc[FULL_W-1:OUT_WIDTH];
`endif
  end

endmodule
